ralu_sequencer: RTL

Multi-cycle control sequencer for the 4-bit register ALU (GPR block, operand registers A/B, parallel ALU). It accepts one instruction per handshake and expands it into per-cycle RALU controls: operand register load, GPR address, B-register shift/load, ALU function, and GPR write-enable. It sits between the central-unit instruction source and the RALU, and it owns every RALU control input.

---
 rtl/ralu_sequencer.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ralu_sequencer.sv
// ralu_sequencer
//   Multi-cycle control sequencer for the 4-bit register ALU (GPR file,
//   operand registers A/B, parallel 74181-style ALU). One instruction is
//   accepted per handshake in IDLE and expanded into per-cycle RALU controls.
//   Every control output is registered: it is decoded from the state and IR
//   that the next edge will hold, so each output lines up with its state.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   instr_valid/instr      instruction offer: [15:13] op, [12:10] rd, [9:7] rs,
//                          [6:3] S/imm/count, [2] M, [1] Pin, [0] serial-in
//   instr_ready            high only while IDLE
//   ralu_data              immediate driven onto RALU DataIn
//   ralu_s/ralu_m/ralu_pin ALU function select, mode, carry-in
//   ralu_a                 regA source (1 = DataIn, 0 = GPR)
//   ralu_wr/ralu_adr       GPR write-enable and address
//   ralu_v                 [0] load regA; [2:1] regB 00 hold/01 shl/10 shr/11 load
//   ralu_isl/ralu_isr      serial-in bits for left/right shifts
//   ralu_osl/ralu_osr      shift-out bits from the RALU
//   done/err               final-cycle pulse / illegal-op pulse
//   flag_c                 last bit shifted out by SHL/SHR
module ralu_sequencer #(
  parameter logic [4:0] FN_PASS_A = 5'b11111,
  parameter logic [4:0] FN_PASS_B = 5'b10101
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  ralu_data,
  output logic [3:0]  ralu_s,
  output logic        ralu_m,
  output logic        ralu_pin,
  output logic        ralu_a,
  output logic        ralu_wr,
  output logic [2:0]  ralu_adr,
  output logic [2:0]  ralu_v,
  output logic        ralu_isl,
  output logic        ralu_isr,
  input  logic        ralu_osl,
  input  logic        ralu_osr,
  output logic        done,
  output logic        err,
  output logic        flag_c
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDA   = 3'd1,
    LDB   = 3'd2,
    SHIFT = 3'd3,
    WB    = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ALU = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;
  logic [15:0] next_ir;
  logic [3:0]  cnt;
  logic [3:0]  next_cnt;

  logic [2:0]  ir_op;
  logic [3:0]  ir_k;
  logic [2:0]  n_op;
  logic [2:0]  n_rd;
  logic [2:0]  n_rs;
  logic [3:0]  n_imm;

  // Next-cycle control values, registered into the outputs below.
  logic [3:0]  n_data;
  logic [3:0]  n_s;
  logic        n_m;
  logic        n_pin;
  logic        n_a;
  logic        n_wr;
  logic [2:0]  n_adr;
  logic [2:0]  n_v;
  logic        n_isl;
  logic        n_isr;
  logic        n_done;
  logic        n_err;

  assign ir_op = ir[15:13];
  assign ir_k  = ir[6:3];
  assign n_op  = next_ir[15:13];
  assign n_rd  = next_ir[12:10];
  assign n_rs  = next_ir[9:7];
  assign n_imm = next_ir[6:3];

  // Next-state, IR capture and shift-counter logic.
  always_comb begin
    next_state = state;
    next_ir    = ir;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          next_ir = instr;
          case (instr[15:13])
            OP_ALU, OP_LDI, OP_MOV: next_state = LDA;
            OP_SHL, OP_SHR:         next_state = LDB;
            default:                next_state = WB;   // NOP and illegal ops
          endcase
        end else begin
          next_state = IDLE;
        end
      end
      LDA: begin
        if (ir_op == OP_ALU) begin
          next_state = LDB;
        end else begin
          next_state = WB;
        end
      end
      LDB: begin
        // A zero shift count goes straight to write-back, rewriting rd unchanged.
        if ((ir_op == OP_SHL || ir_op == OP_SHR) && (ir_k != 4'd0)) begin
          next_state = SHIFT;
          next_cnt   = ir_k;
        end else begin
          next_state = WB;
        end
      end
      SHIFT: begin
        next_cnt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          next_state = WB;
        end else begin
          next_state = SHIFT;
        end
      end
      WB: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Control decode for the state and IR that take effect at the next edge.
  always_comb begin
    n_data = 4'd0;
    n_s    = 4'd0;
    n_m    = 1'b0;
    n_pin  = 1'b0;
    n_a    = 1'b0;
    n_wr   = 1'b0;
    n_adr  = 3'd0;
    n_v    = 3'b000;
    n_isl  = 1'b0;
    n_isr  = 1'b0;
    n_done = 1'b0;
    n_err  = 1'b0;
    case (next_state)
      LDA: begin
        n_v = 3'b001;
        if (n_op == OP_LDI) begin
          n_a    = 1'b1;
          n_data = n_imm;
        end else begin
          n_adr = n_rs;
        end
      end
      LDB: begin
        n_v   = 3'b110;
        n_adr = n_rd;
      end
      SHIFT: begin
        if (n_op == OP_SHL) begin
          n_v   = 3'b010;
          n_isl = next_ir[0];
        end else begin
          n_v   = 3'b100;
          n_isr = next_ir[0];
        end
      end
      WB: begin
        n_done = 1'b1;
        case (n_op)
          OP_NOP: begin
            n_wr = 1'b0;
          end
          OP_ALU: begin
            n_wr          = 1'b1;
            n_adr         = n_rd;
            {n_s, n_m}    = next_ir[6:2];
            n_pin         = next_ir[1];
          end
          OP_LDI, OP_MOV: begin
            n_wr       = 1'b1;
            n_adr      = n_rd;
            {n_s, n_m} = FN_PASS_A;
          end
          OP_SHL, OP_SHR: begin
            n_wr       = 1'b1;
            n_adr      = n_rd;
            {n_s, n_m} = FN_PASS_B;
          end
          default: begin
            n_err = 1'b1;
          end
        endcase
      end
      default: begin
        n_v = 3'b000;
      end
    endcase
  end

  // FSM state, IR, counter, flag and registered RALU control outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ir          <= 16'd0;
      cnt         <= 4'd0;
      flag_c      <= 1'b0;
      instr_ready <= 1'b1;
      ralu_data   <= 4'd0;
      ralu_s      <= 4'd0;
      ralu_m      <= 1'b0;
      ralu_pin    <= 1'b0;
      ralu_a      <= 1'b0;
      ralu_wr     <= 1'b0;
      ralu_adr    <= 3'd0;
      ralu_v      <= 3'b000;
      ralu_isl    <= 1'b0;
      ralu_isr    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= next_state;
      ir          <= next_ir;
      cnt         <= next_cnt;
      instr_ready <= (next_state == IDLE);
      ralu_data   <= n_data;
      ralu_s      <= n_s;
      ralu_m      <= n_m;
      ralu_pin    <= n_pin;
      ralu_a      <= n_a;
      ralu_wr     <= n_wr;
      ralu_adr    <= n_adr;
      ralu_v      <= n_v;
      ralu_isl    <= n_isl;
      ralu_isr    <= n_isr;
      done        <= n_done;
      err         <= n_err;
      // The shift-out bit seen during write-back is the last bit shifted out.
      if (state == WB && ir_op == OP_SHL) begin
        flag_c <= (ir_k == 4'd0) ? 1'b0 : ralu_osl;
      end else if (state == WB && ir_op == OP_SHR) begin
        flag_c <= (ir_k == 4'd0) ? 1'b0 : ralu_osr;
      end else begin
        flag_c <= flag_c;
      end
    end
  end

endmodule
